// File: rtl/bus_generator_n_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bus_generator_n_arbiter_pkg
// Brief    : Shared types and helpers for the bus generator / arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package bus_generator_n_arbiter_pkg;

    localparam int ID_W        = 8;
    localparam int c_max_pkt_w = 256;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        PUSH = 2'd2
    } lane_state_t;

    // Packets narrower than c_max_pkt_w are passed zero-extended.
    function automatic logic [ID_W-1:0] get_dest(input logic [c_max_pkt_w-1:0] pkt,
                                                 input int pkt_w);
        return pkt[pkt_w-1 -: ID_W];
    endfunction

endpackage
`default_nettype wire

// File: rtl/bus_generator_n_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : bus_if
// Brief    : Per-device FIFO handshake bundle for all bus lanes.
// Revision : 1.0 - initial release
// ============================================================================
interface bus_if #(
    parameter int bits    = 1,
    parameter int drvrs   = 4,
    parameter int pckg_sz = 16
);
    logic [bits-1:0][drvrs-1:0]              pndng;
    logic [bits-1:0][drvrs-1:0]              push;
    logic [bits-1:0][drvrs-1:0]              pop;
    logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_pop;
    logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_push;

    modport master (input  pndng, D_pop, output push, pop, D_push);
    modport slave  (output pndng, D_pop, input  push, pop, D_push);
endinterface
`default_nettype wire

// File: rtl/bus_generator_n_arbiter_lane.sv
`default_nettype none
// ============================================================================
// Module   : bus_lane_arbiter
// Brief    : One bus lane: round-robin grant, pop one packet, route it.
// Revision : 1.0 - initial release
// ============================================================================
module bus_lane_arbiter
    import bus_generator_n_arbiter_pkg::*;
#(
    parameter int              DRVRS     = 4,
    parameter int              PCKG_SZ   = 16,
    parameter logic [ID_W-1:0] BROADCAST = 8'hFF
) (
    input  wire logic                           clk,
    input  wire logic                           rst,
    input  wire logic [DRVRS-1:0]               i_pndng,
    input  wire logic [DRVRS-1:0][PCKG_SZ-1:0]  i_d_pop,
    output logic      [DRVRS-1:0]               o_pop,
    output logic      [DRVRS-1:0]               o_push,
    output logic      [PCKG_SZ-1:0]             o_d_push
);

    localparam int               c_sel_w = (DRVRS > 1) ? $clog2(DRVRS) : 1;
    localparam logic [DRVRS-1:0] c_one   = DRVRS'(1);

    lane_state_t          r_state;
    logic [c_sel_w-1:0]   r_last;
    logic [c_sel_w-1:0]   r_sel;
    logic [PCKG_SZ-1:0]   r_pkt;
    logic [DRVRS-1:0]     r_pop;
    logic [DRVRS-1:0]     r_push;

    logic [c_sel_w-1:0]   w_grant;
    logic                 w_any;
    logic [PCKG_SZ-1:0]   w_head;
    logic [ID_W-1:0]      w_dest;
    logic [DRVRS-1:0]     w_push_mask;

    // Scan downward so the nearest requester after r_last wins.
    always_comb begin
        w_grant = '0;
        w_any   = |i_pndng;
        for (int i = DRVRS; i >= 1; i--) begin
            if (i_pndng[c_sel_w'((int'(r_last) + i) % DRVRS)])
                w_grant = c_sel_w'((int'(r_last) + i) % DRVRS);
        end
    end

    assign w_head = i_d_pop[r_sel];
    assign w_dest = get_dest(c_max_pkt_w'(w_head), PCKG_SZ);

    always_comb begin
        w_push_mask = '0;
        for (int d = 0; d < DRVRS; d++) begin
            if (w_dest == BROADCAST)
                w_push_mask[d] = (d != int'(r_sel));
            else
                w_push_mask[d] = (int'(w_dest) == d);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_last  <= c_sel_w'(DRVRS - 1);
            r_sel   <= '0;
            r_pkt   <= '0;
            r_pop   <= '0;
            r_push  <= '0;
        end else begin
            r_pop  <= '0;
            r_push <= '0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_sel   <= w_grant;
                        r_last  <= w_grant;
                        r_pop   <= c_one << w_grant;
                        r_state <= POP;
                    end
                end
                POP: begin
                    r_pkt   <= w_head;
                    r_push  <= w_push_mask;
                    r_state <= PUSH;
                end
                PUSH:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_pop    = r_pop;
    assign o_push   = r_push;
    assign o_d_push = r_pkt;

endmodule
`default_nettype wire

// File: rtl/bus_generator_n_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bus_generator_n_arbiter
// Brief    : Shared-bus generator/arbiter; one independent lane per bus.
// Revision : 1.0 - initial release
// ============================================================================
module bus_generator_n_arbiter
    import bus_generator_n_arbiter_pkg::*;
#(
    parameter int              bits      = 1,
    parameter int              drvrs     = 4,
    parameter int              pckg_sz   = 16,
    parameter logic [ID_W-1:0] broadcast = 8'hFF
) (
    input  wire logic clk,
    input  wire logic reset,
    bus_if.master     bus
);

    logic [bits-1:0][pckg_sz-1:0] w_d_push;

    for (genvar b = 0; b < bits; b++) begin : g_lane
        bus_lane_arbiter #(
            .DRVRS     (drvrs),
            .PCKG_SZ   (pckg_sz),
            .BROADCAST (broadcast)
        ) u_lane (
            .clk      (clk),
            .rst      (reset),
            .i_pndng  (bus.pndng[b]),
            .i_d_pop  (bus.D_pop[b]),
            .o_pop    (bus.pop[b]),
            .o_push   (bus.push[b]),
            .o_d_push (w_d_push[b])
        );

        for (genvar d = 0; d < drvrs; d++) begin : g_dev
            assign bus.D_push[b][d] = w_d_push[b];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bus_generator_n_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_generator_n_arbiter
// Brief    : Self-checking bench with device FIFO models and a transaction model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_generator_n_arbiter;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    bus_if #(.bits(1), .drvrs(4), .pckg_sz(16)) bus ();

    bus_generator_n_arbiter #(
        .bits(1), .drvrs(4), .pckg_sz(16), .broadcast(8'hFF)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] txq [4][$];
    logic [19:0] obs [$];
    bit          rand_arrivals = 1'b0;

    // Transaction model: stage 0 idle, 1 pop cycle, 2 push cycle.
    int          stage;
    int          last;
    int          msel;
    logic [15:0] mpkt;
    logic [3:0]  exp_pop, exp_push, prev_pop;
    logic [15:0] exp_dpush;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] rand_pkt();
        int sel;
        logic [7:0] dest;
        sel = int'($urandom_range(0, 5));
        if (sel < 4)       dest = 8'(sel);
        else if (sel == 4) dest = 8'hFF;
        else               dest = 8'($urandom_range(4, 254));
        return {dest, 8'($urandom)};
    endfunction

    function automatic logic [3:0] deliver_mask(input logic [15:0] pkt, input int src);
        logic [7:0] dest;
        dest = pkt[15:8];
        if (dest == 8'hFF) return 4'hF & ~(4'b0001 << src);
        if (dest < 8'd4)   return 4'b0001 << dest;
        return 4'b0000;
    endfunction

    task automatic model_reset();
        stage     = 0;
        last      = 3;
        exp_pop   = '0;
        exp_push  = '0;
        exp_dpush = '0;
        prev_pop  = '0;
    endtask

    task automatic drive_inputs();
        for (int d = 0; d < 4; d++) begin
            bus.pndng[0][d] = (txq[d].size() != 0);
            bus.D_pop[0][d] = (txq[d].size() != 0) ? txq[d][0] : 16'h0000;
        end
    endtask

    // Drive inputs for the coming edge and predict outputs after it.
    task automatic plan();
        if (rand_arrivals && $urandom_range(0, 3) == 0) begin
            int d;
            d = int'($urandom_range(0, 3));
            if (txq[d].size() < 4) txq[d].push_back(rand_pkt());
        end
        drive_inputs();
        case (stage)
            0: begin
                int s;
                s = -1;
                for (int i = 1; i <= 4; i++) begin
                    int d;
                    d = (last + i) % 4;
                    if (s < 0 && txq[d].size() != 0) s = d;
                end
                exp_push = '0;
                if (s >= 0) begin
                    msel    = s;
                    last    = s;
                    mpkt    = txq[s][0];
                    exp_pop = 4'b0001 << s;
                    stage   = 1;
                end else begin
                    exp_pop = '0;
                end
            end
            1: begin
                exp_pop   = '0;
                exp_push  = deliver_mask(mpkt, msel);
                exp_dpush = mpkt;
                stage     = 2;
            end
            default: begin
                exp_pop  = '0;
                exp_push = '0;
                stage    = 0;
            end
        endcase
    endtask

    task automatic check_outputs();
        check("pop", 32'(bus.pop[0]), 32'(exp_pop));
        check("push", 32'(bus.push[0]), 32'(exp_push));
        for (int d = 0; d < 4; d++)
            check("d_push", 32'(bus.D_push[0][d]), 32'(exp_dpush));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        check_outputs();
        if (bus.push[0] != 4'b0000) obs.push_back({bus.push[0], bus.D_push[0][0]});
        for (int d = 0; d < 4; d++)
            if (prev_pop[d]) void'(txq[d].pop_front());
        prev_pop = exp_pop;
        plan();
    endtask

    task automatic expect_log(input string tag, input int n, input logic [3:0] mask,
                              input logic [15:0] data);
        check({tag, "_count"}, 32'(obs.size()), 32'(n));
        if (n == 1 && obs.size() == 1) begin
            check({tag, "_mask"}, 32'(obs[0][19:16]), 32'(mask));
            check({tag, "_data"}, 32'(obs[0][15:0]), 32'(data));
        end
        obs.delete();
    endtask

    initial begin
        model_reset();
        drive_inputs();
        #6;
        check_outputs();
        #10;
        check_outputs();
        #4;
        reset = 1'b0;
        plan();
        repeat (3) step();
        expect_log("idle", 0, 4'h0, 16'h0000);

        txq[0].push_back(16'h02AB);
        repeat (6) step();
        expect_log("unicast", 1, 4'b0100, 16'h02AB);

        txq[1].push_back(16'hFF5A);
        repeat (6) step();
        expect_log("bcast", 1, 4'b1101, 16'hFF5A);

        txq[3].push_back(16'h0711);
        repeat (6) step();
        expect_log("invalid", 0, 4'h0, 16'h0000);

        for (int s = 0; s < 4; s++)
            for (int k = 0; k < 3; k++)
                txq[s].push_back({8'((s + 1) % 4), 8'(k * 16 + s)});
        repeat (40) step();
        check("rr_count", 32'(obs.size()), 32'd12);
        for (int j = 0; j < 12 && j < obs.size(); j++) begin
            int src;
            src = j % 4;
            check("rr_data", 32'(obs[j][15:0]), 32'({8'((src + 1) % 4), 8'((j / 4) * 16 + src)}));
            check("rr_mask", 32'(obs[j][19:16]), 32'(4'b0001 << ((src + 1) % 4)));
        end
        obs.delete();

        txq[2].push_back(16'h0233);
        repeat (6) step();
        expect_log("self", 1, 4'b0100, 16'h0233);

        txq[0].push_back(16'h0155);
        for (int t = 0; t < 10 && exp_pop == 4'b0000; t++) step();
        check("pop_reached", 32'(exp_pop), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        check("rst_pop", 32'(bus.pop[0]), 32'h0);
        check("rst_push", 32'(bus.push[0]), 32'h0);
        check("rst_dpush", 32'(bus.D_push[0][0]), 32'h0);
        for (int d = 0; d < 4; d++) txq[d].delete();
        model_reset();
        drive_inputs();
        #4;
        reset = 1'b0;
        plan();
        repeat (6) step();
        expect_log("after_rst", 0, 4'h0, 16'h0000);

        rand_arrivals = 1'b1;
        repeat (400) step();
        rand_arrivals = 1'b0;
        repeat (40) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bus_generator_n_arbiter.md
Name: bus_generator_n_arbiter

Overview:
- Shared-bus generator and arbiter connecting `drvrs` devices on each of `bits` independent buses.
- Each device exposes a first-word-fall-through transmit FIFO (`pndng`, `pop`, `D_pop`) and a receive FIFO (`push`, `D_push`).
- The block grants one device per bus in round-robin order, pops one packet from it, and pushes that packet to the destination device(s) encoded in the packet header.
- Sits between the per-device FIFOs/drivers and the system; the bus_if interface bundles its ports.

Parameters:
- bits, 1, number of independent buses (lanes).
- drvrs, 4, number of devices per bus.
- pckg_sz, 16, packet width in bits; must be >= 9.
- broadcast, 8'hFF, destination ID meaning "all devices except the source".

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- pndng  input  [bits-1:0][drvrs-1:0]  device has a packet; `D_pop` is valid while high.
- push  output  [bits-1:0][drvrs-1:0]  one-cycle write strobe into the device receive FIFO.
- pop  output  [bits-1:0][drvrs-1:0]  one-cycle read strobe from the device transmit FIFO.
- D_pop  input  [bits-1:0][drvrs-1:0][pckg_sz-1:0]  head-of-FIFO packet per device.
- D_push  output  [bits-1:0][drvrs-1:0][pckg_sz-1:0]  packet presented to each device's receive FIFO.

Behaviour:
- Packet format:
  - dest ID = `pkt[pckg_sz-1 -: 8]`.
  - Payload = remaining low bits, passed through unmodified.
- Each bus lane is independent and identical; lanes never interact.
- Per-lane FSM has three states:
  - IDLE: if any `pndng[b][*]` is high at the clock edge, latch sel = first requesting device searching from (last_grant+1) mod drvrs upward with wrap-around; set last_grant = sel; go to POP. Otherwise stay in IDLE.
  - POP: `pop[b][sel]` is high for exactly this one cycle. At the closing edge, capture `D_pop[b][sel]` into pkt, then go to PUSH.
  - PUSH: drive `D_push[b][*]` = pkt for all devices. Assert `push[b][d]` for exactly one cycle where:
    - dest == broadcast → every d ≠ sel.
    - dest < drvrs → d = dest, including d == sel.
    - Otherwise (invalid ID) → no push; the packet is dropped.
  - After PUSH, return to IDLE.
- Latency and throughput:
  - `pndng` sampled high at edge k → `pop` high in cycle k..k+1 → `push` high in cycle k+1..k+2.
  - Maximum throughput is one packet per 3 cycles per lane.
- A `pndng` change during POP/PUSH has no effect on the current transaction.
- `D_push` holds the last pkt between transactions; `pop`/`push` are low outside their states.
- Reset (asynchronous, any time, including mid-transaction):
  - All `push`/`pop` = 0, `D_push` = 0, pkt = 0.
  - State = IDLE, last_grant = drvrs-1 (device 0 has first priority).
  - An in-flight packet is abandoned; it is not popped twice nor pushed.
- All `pop`/`push` outputs are registered (glitch-free).

Decomposition:
- Shared package holds:
  - ID_W = 8.
  - Lane state enum {IDLE, POP, PUSH}.
  - A function extracting the dest ID from a packet.
- One sub-module, bus_lane_arbiter: a single-lane FSM, round-robin pointer and packet register. Instantiate it `bits` times via generate.
- Top level is only wiring.

Test Plan (drvrs=4, pckg_sz=16, broadcast=8'hFF, bits=1):
- Reset held 20 ns, no `pndng` → all `pop`/`push`/`D_push` stay 0; assert reset mid-POP → `pop` drops immediately, lane returns to IDLE, no `push` follows.
- Device 0 `pndng` with `D_pop`=16'h02AB → `pop[0]` one cycle, then `push[2]` one cycle with `D_push`=16'h02AB; no other `push`.
- Device 1 sends 16'hFF5A → `push[0]`,`push[2]`,`push[3]` high in the same single cycle, `push[1]` low, `D_push`=16'hFF5A.
- Device 3 sends 16'h0711 (invalid ID 7) → `pop[3]` asserted, no `push` at all; lane idle again 3 cycles after request.
- All four devices hold `pndng` continuously, each packet addressed to (src+1)%4 → grant order 0,1,2,3,0…; one `pop` per 3 cycles; each packet is delivered once to the correct destination.
- Device 2 sends 16'h0233 (self-addressed) → `push[2]` with 16'h0233.
